// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory path: access size, FSM state, word width.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// Load formatting: pick the addressed byte/half lane, then sign- or zero-extend.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        off,
    input  mem_size_t         size,
    input  logic              isUnsigned,
    output logic [WORD_W-1:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Lane select and extension; word loads pass straight through.
    always_comb begin
        byteLane = rdata[{off, 3'b000} +: 8];
        halfLane = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            BYTE:    result = {{24{~isUnsigned & byteLane[7]}}, byteLane};
            HALF:    result = {{16{~isUnsigned & halfLane[15]}}, halfLane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Bridges the single-cycle datapath to a valid/ready data-memory bus.
// Holds the datapath with stall until the bus access completes or times out.
module dmem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              stall,
    output logic              misalign,
    output logic              bus_timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [WORD_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    dmem_state_t       state;
    logic [CNT_W-1:0]  counter;
    logic [1:0]        offQ;
    mem_size_t         sizeQ;
    logic              unsQ;
    logic              isLoadQ;

    logic              req;
    logic              badReq;
    logic [3:0]        nextBe;
    logic [WORD_W-1:0] nextWdata;
    logic [WORD_W-1:0] loadResult;

    assign req = mem_read | mem_write;

    // Alignment check; size 11 is never legal.
    always_comb begin
        case (size)
            2'b00:   badReq = 1'b0;
            2'b01:   badReq = addr[0];
            2'b10:   badReq = |addr[1:0];
            default: badReq = 1'b1;
        endcase
    end

    // Misalign only means something while a new request is being decoded.
    assign misalign = reset & (state == IDLE) & req & badReq;
    assign stall    = reset & (((state == IDLE) & req & ~badReq) | (state == ACCESS));

    // Store lane steering: replicate data across lanes, enable only the target bytes.
    always_comb begin
        case (size)
            2'b00: begin
                nextBe    = 4'b0001 << addr[1:0];
                nextWdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                nextBe    = addr[1] ? 4'b1100 : 4'b0011;
                nextWdata = {2{write_data[15:0]}};
            end
            default: begin
                nextBe    = 4'b1111;
                nextWdata = write_data;
            end
        endcase
    end

    load_align uLoadAlign (
        .rdata      (bus_rdata),
        .off        (offQ),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .result     (loadResult)
    );

    // Access FSM with registered bus outputs and load result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            read_data   <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            bus_timeout <= 1'b0;
            offQ        <= '0;
            sizeQ       <= BYTE;
            unsQ        <= 1'b0;
            isLoadQ     <= 1'b0;
        end else begin
            bus_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (badReq) begin
                            read_data <= '0;
                        end else begin
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_we    <= mem_write;
                            bus_be    <= nextBe;
                            bus_wdata <= nextWdata;
                            offQ      <= addr[1:0];
                            sizeQ     <= mem_size_t'(size);
                            unsQ      <= ld_unsigned;
                            // A simultaneous read+write is treated as a store.
                            isLoadQ   <= mem_read & ~mem_write;
                            bus_req   <= 1'b1;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    counter <= counter + CNT_W'(1);
                    if (bus_ready) begin
                        if (isLoadQ) read_data <= loadResult;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (counter == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_req     <= 1'b0;
                        bus_timeout <= 1'b1;
                        read_data   <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    counter <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits directly downstream of the single-cycle datapath. Consumes its aluOut (address), writeData and memory control signals, and returns readData.
- Bridges the datapath to a multi-cycle data-memory bus with a valid/ready handshake. Handles byte and halfword lane steering, load sign/zero extension, misalignment detection and bus timeout.
- Asserts stall so the datapath holds its PC and register writes until the access completes.

Parameters:
- ADDR_W, 32, address width on both the datapath and bus sides.
- TIMEOUT_CYCLES, 16, maximum cycles spent in ACCESS waiting for bus_ready; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low: when 0 at a rising clk edge, all state resets
- mem_read  in  1  load request (datapath memToReg path)
- mem_write  in  1  store request (datapath memWrite)
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- ld_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- addr  in  ADDR_W  byte address (datapath aluOut)
- write_data  in  32  store data (datapath writeData)
- read_data  out  32  formatted load result (to datapath readData)
- stall  out  1  holds the datapath this cycle
- misalign  out  1  current request is misaligned or has illegal size
- bus_timeout  out  1  one-cycle pulse when an access is abandoned
- bus_req  out  1  bus valid
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  bus completes the access this cycle
- bus_rdata  in  32  bus read word, valid when bus_ready=1

Behaviour:
- Reset values: state=IDLE, counter=0, read_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, bus_timeout=0. stall and misalign are 0 while reset=0.
- Request: req = mem_read | mem_write. If both are 1, the access is a write and no load data is returned.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0. misalign = req & (misaligned | size==11). It is combinational and valid in IDLE only.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, req & !misalign: latch bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata, the byte offset, size and ld_unsigned. Go to ACCESS. bus_req is registered, so it is 1 in the first ACCESS cycle.
- IDLE, req & misalign: no bus access, stall=0, state stays IDLE, read_data=0 on the next edge. The datapath must drop the op.
- ACCESS: bus_req=1 and counter increments each cycle.
  - bus_ready=1: capture the formatted bus_rdata into read_data (loads only), drop bus_req, go to DONE.
  - bus_ready=0 when counter==TIMEOUT_CYCLES-1: drop bus_req, pulse bus_timeout, read_data=0, go to DONE.
- DONE: stall=0, read_data is held stable, datapath commits on this edge. Go to IDLE unconditionally; counter clears to 0.
- stall = (IDLE & req & !misalign) | ACCESS. It is combinational.
- Latency: with bus_ready in the first ACCESS cycle, a memory instruction occupies 3 cycles (2 stall cycles). Each extra wait cycle adds one.
- Store lane steering:
  - byte: be = 1<<off; wdata = {4{wd[7:0]}}
  - half: be = off[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}
  - word: be = 1111; wdata = wd
- Load formatting: select byte lane off or half lane off[1], then sign- or zero-extend to 32 bits. Word loads pass through.
- Bus protocol: bus_addr, bus_we, bus_be and bus_wdata are stable while bus_req=1. bus_ready is ignored outside ACCESS.
- Reset mid-access: when reset=0, the next edge returns to IDLE and drops bus_req. No further bus cycle is issued.

Decomposition:
- Shared package (mips_mem_pkg):
  - mem_size_t enum (BYTE, HALF, WORD)
  - dmem_state_t enum (IDLE, ACCESS, DONE)
  - width constant WORD_W=32
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, off, size, unsigned → 32-bit result). It is reused later by an instruction-fetch unit.

Test Plan:
- sw: addr=0x104, wd=0xDEADBEEF, bus_ready after 2 cycles → bus_addr=0x104, be=1111, wdata=0xDEADBEEF; stall high 3 cycles, then low for 1 cycle (DONE).
- sb: addr=0x103, wd=0x000000A5 → be=1000, wdata=0xA5A5A5A5, bus_we=1.
- lb/lbu: addr=0x202, bus_rdata=0x1280FF00.
  - signed load → read_data=0xFFFFFF80
  - ld_unsigned=1 → read_data=0x00000080
- lh: addr=0x001, size=01 → misalign=1, stall=0, bus_req stays 0, read_data=0.
- Timeout: lw with bus_ready held 0 → bus_timeout pulses exactly once on the 16th ACCESS cycle, bus_req drops, read_data=0, FSM returns to IDLE after DONE.
- Reset mid-access: reset=0 during ACCESS → bus_req=0 and stall=0 after the next edge. A new lw after reset is released completes normally.
